// File: rtl/data_modulate_kxk_controller_if.sv
// Handshake/status bundle between pixel source and the KxK window controller.
// err_o exists only when DATA_MODULATE_ERR_EN is defined.
interface data_modulate_kxk_controller_if #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 6,
   parameter int CW    = $clog2(IMG_W),
   parameter int RW    = $clog2(IMG_H)
);
   logic          start_i;
   logic          valid_i;
   logic          done_i;
   logic          start_o;
   logic          valid_o;
   logic          flush_o;
   logic          done_o;
   logic          busy_o;
   logic [CW-1:0] col_o;
   logic [RW-1:0] row_o;
`ifdef DATA_MODULATE_ERR_EN
   logic          err_o;
`endif

   // master = pixel source side, slave = controller side
   modport master (
      output start_i, valid_i, done_i,
`ifdef DATA_MODULATE_ERR_EN
      input  err_o,
`endif
      input  start_o, valid_o, flush_o, done_o, busy_o, col_o, row_o
   );

   modport slave (
      input  start_i, valid_i, done_i,
`ifdef DATA_MODULATE_ERR_EN
      output err_o,
`endif
      output start_o, valid_o, flush_o, done_o, busy_o, col_o, row_o
   );
endinterface

// File: rtl/data_modulate_kxk_controller.sv
// Frame/window controller for the KxK sliding-window path: tracks col/row, flags full windows,
// flushes K-1 cycles after frame end, then pulses done. Optional `DATA_MODULATE_ERR_EN adds err_o.
module data_modulate_kxk_controller #(
   parameter int K     = 5,
   parameter int IMG_W = 8,
   parameter int IMG_H = 6,
   parameter int CW    = $clog2(IMG_W),
   parameter int RW    = $clog2(IMG_H)
) (
   input  logic clk,
   input  logic rst,
   data_modulate_kxk_controller_if.slave bus
);
   localparam int FW = $clog2(K);
   localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_WIN    = CW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_WIN    = RW'(K - 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(K - 2);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          start_q, start_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;
   logic          win_hit;

`ifdef DATA_MODULATE_ERR_EN
   localparam int PW = $clog2(IMG_W * IMG_H + 1) + 1;
   localparam logic [PW-1:0] PIX_TOTAL = PW'(IMG_W * IMG_H);
   logic [PW-1:0] pix_q, pix_d;
   logic          err_q, err_d;
`endif

   // Window test uses the position of the pixel being accepted, before the counters advance.
   assign win_hit = (row_q >= ROW_WIN) && (col_q >= COL_WIN);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      fcnt_d  = fcnt_q;
      start_d = 1'b0;
      valid_d = 1'b0;
      done_d  = done_q;
`ifdef DATA_MODULATE_ERR_EN
      pix_d   = pix_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               state_d = S_FILL;
               col_d   = '0;
               row_d   = '0;
               fcnt_d  = '0;
               start_d = 1'b1;
               done_d  = 1'b0;
`ifdef DATA_MODULATE_ERR_EN
               pix_d   = '0;
               err_d   = 1'b0;
`endif
            end
         end
         S_FILL, S_RUN: begin
            if (bus.valid_i) begin
               valid_d = win_hit;
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q != ROW_LAST) row_d = row_q + RW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
               if (state_q == S_FILL && win_hit) state_d = S_RUN;
`ifdef DATA_MODULATE_ERR_EN
               if (pix_q != '1) pix_d = pix_q + PW'(1);
`endif
            end
            // A pixel arriving with done_i is already folded into col/row/pix above.
            if (bus.done_i) begin
               state_d = S_FLUSH;
               fcnt_d  = '0;
`ifdef DATA_MODULATE_ERR_EN
               if (pix_d != PIX_TOTAL) err_d = 1'b1;
`endif
            end
         end
         S_FLUSH: begin
            if (fcnt_q == FLUSH_LAST) state_d = S_DONE;
            else                      fcnt_d  = fcnt_q + FW'(1);
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         fcnt_q  <= '0;
         start_q <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef DATA_MODULATE_ERR_EN
         pix_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         fcnt_q  <= fcnt_d;
         start_q <= start_d;
         valid_q <= valid_d;
         done_q  <= done_d;
`ifdef DATA_MODULATE_ERR_EN
         pix_q   <= pix_d;
         err_q   <= err_d;
`endif
      end
   end

   assign bus.start_o = start_q;
   assign bus.valid_o = valid_q;
   assign bus.flush_o = (state_q == S_FLUSH);
   assign bus.done_o  = (state_q == S_DONE) && !done_q;
   assign bus.busy_o  = (state_q != S_IDLE);
   assign bus.col_o   = col_q;
   assign bus.row_o   = row_q;
`ifdef DATA_MODULATE_ERR_EN
   assign bus.err_o   = err_q;
`endif
endmodule

// File: tb/tb_data_modulate_kxk_controller.sv
// Randomised self-checking bench for data_modulate_kxk_controller against a frame-timeline model.
`timescale 1ns/1ps
module tb_data_modulate_kxk_controller;
   localparam int K    = 5;
   localparam int W    = 8;
   localparam int H    = 6;
   localparam int CW   = $clog2(W);
   localparam int RW   = $clog2(H);
   localparam int MAXC = 256;
   localparam int OW   = CW + RW + 6;
   localparam int BUSY_B  = CW + RW;
   localparam int DONE_B  = CW + RW + 1;
   localparam int FLUSH_B = CW + RW + 2;
   localparam int VALID_B = CW + RW + 3;
   localparam int START_B = CW + RW + 4;
   localparam int ERR_B   = CW + RW + 5;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   data_modulate_kxk_controller_if #(.IMG_W(W), .IMG_H(H)) bus ();

   data_modulate_kxk_controller #(.K(K), .IMG_W(W), .IMG_H(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   bit            st_a [MAXC];
   bit            va_a [MAXC];
   bit            dn_a [MAXC];
   logic [OW-1:0] obs_a[MAXC];
   logic [OW-1:0] exp_a[MAXC];

   // Model: frame timeline (idle / accepting pixels / tail after done_i) plus a pixel tally.
   bit m_busy, m_act, m_err;
   int m_t, m_cnt;

   function automatic int row_of(int p);
      return (p / W > H - 1) ? H - 1 : p / W;
   endfunction

   function automatic bit win(int p);
      return (p % W >= K - 1) && (row_of(p) >= K - 1);
   endfunction

   function automatic logic [OW-1:0] pack_obs();
      logic e;
`ifdef DATA_MODULATE_ERR_EN
      e = bus.err_o;
`else
      e = 1'b0;
`endif
      return {e, bus.start_o, bus.valid_o, bus.flush_o, bus.done_o, bus.busy_o, bus.col_o, bus.row_o};
   endfunction

   task automatic model_reset();
      m_busy = 0; m_act = 0; m_err = 0; m_t = 0; m_cnt = 0;
   endtask

   task automatic model_step(input bit st, input bit va, input bit dn, output logic [OW-1:0] e);
      bit s_o, v_o, fl, dn_o, er;
      s_o = 0; v_o = 0;
      if (!m_busy) begin
         if (st) begin
            m_busy = 1; m_act = 1; m_t = 0; m_cnt = 0; m_err = 0; s_o = 1;
         end
      end else if (m_act) begin
         if (va) begin
            v_o = win(m_cnt);
            m_cnt++;
         end
         if (dn) begin
            m_act = 0; m_t = 0;
            if (m_cnt != W * H) m_err = 1;
         end
      end else begin
         m_t++;
         if (m_t == K) m_busy = 0;
      end
      fl   = m_busy && !m_act && (m_t <= K - 2);
      dn_o = m_busy && !m_act && (m_t == K - 1);
`ifdef DATA_MODULATE_ERR_EN
      er = m_err;
`else
      er = 1'b0;
`endif
      e = {er, s_o, v_o, fl, dn_o, m_busy, CW'(m_cnt % W), RW'(row_of(m_cnt))};
   endtask

   task automatic clear_stim();
      for (int i = 0; i < MAXC; i++) begin
         st_a[i] = 0; va_a[i] = 0; dn_a[i] = 0;
      end
   endtask

   // Called at posedge+1; inputs of step i are sampled at the next edge, outputs read 1ns after it.
   task automatic run_seq(input int n);
      logic [OW-1:0] e;
      for (int i = 0; i < n; i++) begin
         bus.start_i = st_a[i];
         bus.valid_i = va_a[i];
         bus.done_i  = dn_a[i];
         model_step(st_a[i], va_a[i], dn_a[i], e);
         exp_a[i] = e;
         @(posedge clk);
         #1;
         obs_a[i] = pack_obs();
      end
      bus.start_i = 0; bus.valid_i = 0; bus.done_i = 0;
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b0;
      bus.start_i = 0; bus.valid_i = 0; bus.done_i = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (pack_obs() !== '0) begin
         bad++; $display("FAIL reset_init got=%b want=%b", pack_obs(), {OW{1'b0}});
      end
      rst = 1'b1;
      clear_stim();
      st_a[0] = 1;
      for (int i = 1; i <= 20; i++) va_a[i] = 1;
      n = 21;
      run_seq(n);
      for (int i = 0; i < n; i++) begin
         total++;
         if (obs_a[i] !== exp_a[i]) begin
            bad++; $display("FAIL reset_prerun cyc=%0d got=%b want=%b", i, obs_a[i], exp_a[i]);
         end
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if (pack_obs() !== '0) begin
         bad++; $display("FAIL reset_async got=%b want=%b", pack_obs(), {OW{1'b0}});
      end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      $display("test_reset: checks so far=%0d", total);
   endtask

   task automatic test_full_frame();
      int n, vcount, first_v, fcount;
      clear_stim();
      st_a[0] = 1;
      for (int i = 1; i <= W * H; i++) va_a[i] = 1;
      dn_a[W * H + 2] = 1;
      for (int i = W * H + 3; i < W * H + 3 + K; i++) va_a[i] = 1'($urandom % 2);
      n = W * H + 3 + K + 3;
      run_seq(n);
      vcount = 0; first_v = -1; fcount = 0;
      for (int i = 0; i < n; i++) begin
         total++;
         if (obs_a[i] !== exp_a[i]) begin
            bad++; $display("FAIL full_frame cyc=%0d got=%b want=%b", i, obs_a[i], exp_a[i]);
         end
         if (obs_a[i][VALID_B]) begin
            vcount++;
            if (first_v < 0) first_v = i;
         end
         if (obs_a[i][FLUSH_B]) fcount++;
      end
      total++;
      if (vcount != 8) begin bad++; $display("FAIL full_frame_vcount got=%0d want=8", vcount); end
      total++;
      if (first_v != 37) begin bad++; $display("FAIL full_frame_first_valid got=%0d want=37", first_v); end
      total++;
      if (fcount != K - 1) begin bad++; $display("FAIL full_frame_flush_len got=%0d want=%0d", fcount, K - 1); end
      total++;
      if (obs_a[W * H + 2 + K - 1][DONE_B] !== 1'b1 || obs_a[W * H + 2 + K][BUSY_B] !== 1'b0) begin
         bad++; $display("FAIL full_frame_done_timing done=%b busy_after=%b want=1/0",
                         obs_a[W * H + 2 + K - 1][DONE_B], obs_a[W * H + 2 + K][BUSY_B]);
      end
      total++;
      if (obs_a[n - 1][CW+RW-1:0] !== {CW'(0), RW'(H - 1)}) begin
         bad++; $display("FAIL full_frame_final_pos got=%b want=%b", obs_a[n - 1][CW+RW-1:0], {CW'(0), RW'(H - 1)});
      end
      $display("test_full_frame: valid pulses=%0d first at %0d", vcount, first_v);
   endtask

   task automatic test_gapped();
      int n, vcount, last;
      clear_stim();
      st_a[0] = 1;
      for (int p = 0; p < W * H; p++) va_a[1 + 2 * p] = 1;
      last = 1 + 2 * (W * H - 1);
      dn_a[last] = 1;
      n = last + K + 3;
      run_seq(n);
      vcount = 0;
      for (int i = 0; i < n; i++) begin
         total++;
         if (obs_a[i] !== exp_a[i]) begin
            bad++; $display("FAIL gapped cyc=%0d got=%b want=%b", i, obs_a[i], exp_a[i]);
         end
         if (obs_a[i][VALID_B]) vcount++;
      end
      total++;
      if (vcount != 8) begin bad++; $display("FAIL gapped_vcount got=%0d want=8", vcount); end
      total++;
      if (obs_a[last][FLUSH_B] !== 1'b1 || obs_a[last][VALID_B] !== 1'b1) begin
         bad++; $display("FAIL gapped_last_pixel flush=%b valid=%b want=1/1", obs_a[last][FLUSH_B], obs_a[last][VALID_B]);
      end
      $display("test_gapped: valid pulses=%0d", vcount);
   endtask

   task automatic test_ignored();
      int n, dcount, spulse;
      clear_stim();
      st_a[0] = 1;
      for (int i = 1; i <= 30; i++) begin
         va_a[i] = 1;
         st_a[i] = 1'($urandom % 2);
      end
      va_a[31] = 1; dn_a[31] = 1;
      for (int i = 32; i < 32 + K + 4; i++) begin
         dn_a[i] = 1;
         va_a[i] = 1'($urandom % 2);
         st_a[i] = (i < 32 + K - 1);
      end
      n = 32 + K + 4;
      run_seq(n);
      dcount = 0; spulse = 0;
      for (int i = 0; i < n; i++) begin
         total++;
         if (obs_a[i] !== exp_a[i]) begin
            bad++; $display("FAIL ignored cyc=%0d got=%b want=%b", i, obs_a[i], exp_a[i]);
         end
         if (obs_a[i][DONE_B]) dcount++;
         if (obs_a[i][START_B]) spulse++;
      end
      total++;
      if (dcount != 1) begin bad++; $display("FAIL ignored_done_count got=%0d want=1", dcount); end
      total++;
      if (spulse != 1) begin bad++; $display("FAIL ignored_start_count got=%0d want=1", spulse); end
      $display("test_ignored: done pulses=%0d start pulses=%0d", dcount, spulse);
   endtask

   task automatic test_random();
      int n;
      for (int r = 0; r < 3; r++) begin
         clear_stim();
         n = 200;
         for (int i = 0; i < n; i++) begin
            st_a[i] = ($urandom % 8 == 0);
            va_a[i] = ($urandom % 4 != 0);
            dn_a[i] = ($urandom % 40 == 0);
         end
         run_seq(n);
         for (int i = 0; i < n; i++) begin
            total++;
            if (obs_a[i] !== exp_a[i]) begin
               bad++; $display("FAIL random r=%0d cyc=%0d got=%b want=%b", r, i, obs_a[i], exp_a[i]);
            end
         end
         $display("test_random: round %0d of %0d cycles", r, n);
      end
   endtask

`ifdef DATA_MODULATE_ERR_EN
   task automatic test_err();
      int n;
      clear_stim();
      st_a[0] = 1;
      for (int i = 1; i <= 40; i++) va_a[i] = 1;
      dn_a[41] = 1;
      n = 41 + K + 2;
      run_seq(n);
      for (int i = 0; i < n; i++) begin
         total++;
         if (obs_a[i] !== exp_a[i]) begin
            bad++; $display("FAIL err_frame cyc=%0d got=%b want=%b", i, obs_a[i], exp_a[i]);
         end
      end
      total++;
      if (obs_a[41][ERR_B] !== 1'b1 || obs_a[n - 1][ERR_B] !== 1'b1) begin
         bad++; $display("FAIL err_set got=%b/%b want=1/1", obs_a[41][ERR_B], obs_a[n - 1][ERR_B]);
      end
      total++;
      if (obs_a[41 + K - 1][DONE_B] !== 1'b1) begin
         bad++; $display("FAIL err_done_timing got=%b want=1", obs_a[41 + K - 1][DONE_B]);
      end
      clear_stim();
      st_a[0] = 1;
      va_a[1] = 1;
      run_seq(2);
      total++;
      if (obs_a[0][ERR_B] !== 1'b0) begin
         bad++; $display("FAIL err_clear got=%b want=0", obs_a[0][ERR_B]);
      end
      clear_stim();
      dn_a[0] = 1;
      run_seq(K + 2);
      $display("test_err: err after short frame=%b", obs_a[41][ERR_B]);
   endtask
`endif

   initial begin
      test_reset();
      test_full_frame();
      test_gapped();
      test_ignored();
`ifdef DATA_MODULATE_ERR_EN
      test_err();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
